lsu_mmio: RTL and testbench



---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_lane.sv | 48 ++++
 rtl/lsu_mmio.sv | 176 +++++++++++++++++
 tb/tb_lsu_mmio.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and constants for the load/store MMIO unit.
// Access sizes, FSM states and the fixed region map live here.
package lsu_pkg;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int DEFAULT_OFFSET_BITS = 8;

  localparam int REGION_ROM   = 0;
  localparam int REGION_RAM   = 1;
  localparam int REGION_UART  = 2;
  localparam int REGION_RAMIO = 3;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store replication, byte enables, load shift and extend.
// Purely combinational; an illegal size yields all-zero outputs.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  hb_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic        sext_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    wdata_o = '0;
    be_o    = '0;
    rdata_o = '0;
    unique case (hb_i)
      HB_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
        rdata_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
      end
      HB_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        be_o    = 4'b0011 << addr_lo_i;
        rdata_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
      end
      HB_WORD: begin
        wdata_o = wdata_i;
        be_o    = 4'b1111;
        rdata_o = shifted;
      end
      default: begin
        wdata_o = '0;
        be_o    = '0;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mmio.sv
// Load/store unit bridging the core data port to the chip-selected MMIO bus.
// Decodes the region, holds the access until ack or timeout, returns an aligned result.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int N_SLAVES    = 4,
  parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS,
  parameter int TIMEOUT     = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     core_req_i,
  input  logic                     core_we_i,
  input  logic [31:0]              core_addr_i,
  input  logic [31:0]              core_wdata_i,
  input  logic [1:0]               core_hb_i,
  input  logic                     core_sext_i,
  output logic                     core_busy_o,
  output logic                     core_done_o,
  output logic [31:0]              core_rdata_o,
  output logic                     core_err_o,
  output logic [31:0]              bus_addr_o,
  output logic [31:0]              bus_wdata_o,
  output logic [3:0]               bus_be_o,
  output logic                     bus_we_o,
  output logic [N_SLAVES-1:0]      bus_cs_o,
  input  logic [32*N_SLAVES-1:0]   bus_rdata_i,
  input  logic [N_SLAVES-1:0]      bus_ack_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [3:0]          sel_q;
  logic [1:0]          addr_lo_q;
  logic [1:0]          hb_q;
  logic                sext_q;
  logic                we_q;
  logic [31:0]         bus_addr_q;
  logic [31:0]         bus_wdata_q;
  logic [3:0]          bus_be_q;
  logic                bus_we_q;
  logic [N_SLAVES-1:0] bus_cs_q;
  logic                done_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic [3:0]          region;
  logic                dec_err;
  logic [N_SLAVES-1:0] cs_dec;
  logic [31:0]         sel_rdata;
  logic                sel_ack;
  logic                idle;
  logic [31:0]         lane_wdata;
  logic [3:0]          lane_be;
  logic [31:0]         lane_rdata;
  logic                unused_addr_hi;

  assign idle           = (state_q == ST_IDLE);
  assign region         = core_addr_i[OFFSET_BITS +: 4];
  assign unused_addr_hi = ^core_addr_i[31:OFFSET_BITS+4];

  assign dec_err = ((core_hb_i == HB_HALF) && core_addr_i[0])
                || ((core_hb_i == HB_WORD) && (core_addr_i[1:0] != 2'b00))
                || (core_hb_i == 2'b11)
                || ({1'b0, region} >= 5'(N_SLAVES));

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_cs
    assign cs_dec[gi] = (region == 4'(gi));
  end

  // Only the latched region may complete the access; other acks are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ack   = 1'b0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_q == 4'(k)) begin
        sel_rdata = bus_rdata_i[32*k +: 32];
        sel_ack   = bus_ack_i[k];
      end
    end
  end

  // One lane instance: fed by the core inputs at decode, by latched fields afterwards.
  lsu_lane u_lane (
    .hb_i      (idle ? core_hb_i : hb_q),
    .addr_lo_i (idle ? core_addr_i[1:0] : addr_lo_q),
    .wdata_i   (core_wdata_i),
    .sext_i    (sext_q),
    .rdata_i   (sel_rdata),
    .wdata_o   (lane_wdata),
    .be_o      (lane_be),
    .rdata_o   (lane_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      addr_lo_q   <= '0;
      hb_q        <= '0;
      sext_q      <= 1'b0;
      we_q        <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      bus_we_q    <= 1'b0;
      bus_cs_q    <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (core_req_i) begin
            sel_q     <= region;
            addr_lo_q <= core_addr_i[1:0];
            hb_q      <= core_hb_i;
            sext_q    <= core_sext_i;
            we_q      <= core_we_i;
            cnt_q     <= '0;
            if (dec_err) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q     <= ST_ACCESS;
              bus_addr_q  <= 32'(core_addr_i[OFFSET_BITS-1:0]);
              bus_wdata_q <= lane_wdata;
              bus_be_q    <= lane_be;
              bus_we_q    <= core_we_i;
              bus_cs_q    <= cs_dec;
            end
          end
        end
        ST_ACCESS: begin
          // Ack is tested first so it wins over a same-cycle timeout.
          if (sel_ack) begin
            state_q  <= ST_RESP;
            done_q   <= 1'b1;
            err_q    <= 1'b0;
            rdata_q  <= we_q ? 32'd0 : lane_rdata;
            bus_cs_q <= '0;
            bus_we_q <= 1'b0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q  <= ST_RESP;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
            bus_cs_q <= '0;
            bus_we_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_busy_o  = (state_q == ST_ACCESS) || (state_q == ST_RESP);
  assign core_done_o  = done_q;
  assign core_rdata_o = rdata_q;
  assign core_err_o   = err_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_wdata_o  = bus_wdata_q;
  assign bus_be_o     = bus_be_q;
  assign bus_we_o     = bus_we_q;
  assign bus_cs_o     = bus_cs_q;

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed bench for lsu_mmio: loads, stores, decode errors, timeout and reset abort.
module tb_lsu_mmio;
  import lsu_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         core_req;
  logic         core_we;
  logic [31:0]  core_addr;
  logic [31:0]  core_wdata;
  logic [1:0]   core_hb;
  logic         core_sext;
  logic         core_busy;
  logic         core_done;
  logic [31:0]  core_rdata;
  logic         core_err;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic [3:0]   bus_be;
  logic         bus_we;
  logic [3:0]   bus_cs;
  logic [127:0] bus_rdata;
  logic [3:0]   bus_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mmio #(.N_SLAVES(4), .OFFSET_BITS(8), .TIMEOUT(15)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_addr_i  (core_addr),
    .core_wdata_i (core_wdata),
    .core_hb_i    (core_hb),
    .core_sext_i  (core_sext),
    .core_busy_o  (core_busy),
    .core_done_o  (core_done),
    .core_rdata_o (core_rdata),
    .core_err_o   (core_err),
    .bus_addr_o   (bus_addr),
    .bus_wdata_o  (bus_wdata),
    .bus_be_o     (bus_be),
    .bus_we_o     (bus_we),
    .bus_cs_o     (bus_cs),
    .bus_rdata_i  (bus_rdata),
    .bus_ack_i    (bus_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle request at a falling edge; returns in the first cycle after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] hb, input logic sext);
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
    core_hb    = hb;
    core_sext  = sext;
    core_req   = 1'b1;
    @(negedge clk);
    core_req   = 1'b0;
  endtask

  task automatic run_ack(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] hb, input logic sext,
                         input logic [31:0] slave_data, input logic [3:0] exp_cs,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata);
    int s;
    s = int'(addr[11:8]);
    bus_rdata[32*s +: 32] = slave_data;
    issue(we, addr, wdata, hb, sext);
    chk({name, "_cs"},    32'(bus_cs), 32'(exp_cs));
    chk({name, "_be"},    32'(bus_be), 32'(exp_be));
    chk({name, "_we"},    32'(bus_we), 32'(we));
    chk({name, "_wdata"}, bus_wdata, exp_wdata);
    chk({name, "_baddr"}, bus_addr, {24'd0, addr[7:0]});
    chk({name, "_busy"},  32'(core_busy), 32'd1);
    chk({name, "_early"}, 32'(core_done), 32'd0);
    bus_ack[s] = 1'b1;
    @(negedge clk);
    bus_ack = '0;
    chk({name, "_done"},  32'(core_done), 32'd1);
    chk({name, "_err"},   32'(core_err), 32'd0);
    chk({name, "_rdata"}, core_rdata, exp_rdata);
    chk({name, "_csoff"}, 32'(bus_cs), 32'd0);
    @(negedge clk);
    chk({name, "_pulse"}, 32'(core_done), 32'd0);
    chk({name, "_idle"},  32'(core_busy), 32'd0);
    chk({name, "_hold"},  core_rdata, exp_rdata);
    $display("txn %-12s we=%0d addr=%08h hb=%0d cs=%b be=%b rdata=%08h", name, we, addr, hb,
             exp_cs, exp_be, core_rdata);
  endtask

  task automatic err_case(input string name, input logic [31:0] addr, input logic [1:0] hb);
    bus_ack = 4'b1111;
    issue(1'b0, addr, 32'd0, hb, 1'b0);
    chk({name, "_done"}, 32'(core_done), 32'd1);
    chk({name, "_err"},  32'(core_err), 32'd1);
    chk({name, "_cs"},   32'(bus_cs), 32'd0);
    chk({name, "_busy"}, 32'(core_busy), 32'd1);
    @(negedge clk);
    bus_ack = '0;
    chk({name, "_pulse"}, 32'(core_done), 32'd0);
    chk({name, "_cs2"},   32'(bus_cs), 32'd0);
    chk({name, "_idle"},  32'(core_busy), 32'd0);
    $display("txn %-12s addr=%08h hb=%0d err=%0d", name, addr, hb, core_err);
  endtask

  initial begin
    rst        = 1'b1;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    core_hb    = HB_WORD;
    core_sext  = 1'b0;
    bus_rdata  = '0;
    bus_ack    = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(core_busy), 32'd0);
    chk("rst_done",  32'(core_done), 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_err",   32'(core_err), 32'd0);
    chk("rst_cs",    32'(bus_cs), 32'd0);
    chk("rst_be",    32'(bus_be), 32'd0);
    chk("rst_we",    32'(bus_we), 32'd0);
    chk("rst_baddr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_ack("ld_word_r1", 1'b0, 32'h0000_0104, 32'd0, HB_WORD, 1'b0, 32'hDEAD_BEEF,
            4'b0010, 4'b1111, 32'd0, 32'hDEAD_BEEF);
    run_ack("ld_byte_sx", 1'b0, 32'h0000_0203, 32'd0, HB_BYTE, 1'b1, 32'h8000_0000,
            4'b0100, 4'b1000, 32'd0, 32'hFFFF_FF80);
    run_ack("ld_byte_zx", 1'b0, 32'h0000_0203, 32'd0, HB_BYTE, 1'b0, 32'h8000_0000,
            4'b0100, 4'b1000, 32'd0, 32'h0000_0080);
    run_ack("ld_half_sx", 1'b0, 32'h0000_0102, 32'd0, HB_HALF, 1'b1, 32'h8001_0000,
            4'b0010, 4'b1100, 32'd0, 32'hFFFF_8001);

    // Timeout on region 0 while a stray ack toggles on slave 2.
    bus_rdata[31:0] = 32'h1234_5678;
    issue(1'b0, 32'h0000_0000, 32'd0, HB_WORD, 1'b0);
    bus_ack = 4'b0100;
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("to_cs_%0d", i),   32'(bus_cs), 32'd1);
      chk($sformatf("to_done_%0d", i), 32'(core_done), 32'd0);
      @(negedge clk);
    end
    bus_ack = '0;
    chk("to_done",  32'(core_done), 32'd1);
    chk("to_err",   32'(core_err), 32'd1);
    chk("to_rdata", core_rdata, 32'd0);
    @(negedge clk);
    chk("to_idle",  32'(core_busy), 32'd0);
    $display("txn %-12s addr=%08h err=%0d rdata=%08h", "timeout", 32'h0, core_err, core_rdata);

    run_ack("st_half",    1'b1, 32'h0000_0302, 32'h0000_ABCD, HB_HALF, 1'b0, 32'h5555_5555,
            4'b1000, 4'b1100, 32'hABCD_ABCD, 32'd0);
    run_ack("st_byte",    1'b1, 32'h0000_0001, 32'h0000_00A5, HB_BYTE, 1'b0, 32'h5555_5555,
            4'b0001, 4'b0010, 32'hA5A5_A5A5, 32'd0);

    err_case("err_misw", 32'h0000_0102, HB_WORD);
    err_case("err_mish", 32'h0000_0101, HB_HALF);
    err_case("err_hb11", 32'h0000_0100, 2'b11);
    err_case("err_reg4", 32'h0000_0400, HB_WORD);

    // Ack arriving in the final ACCESS cycle beats the timeout.
    bus_rdata[63:32] = 32'hCAFE_F00D;
    issue(1'b0, 32'h0000_0100, 32'd0, HB_WORD, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      chk($sformatf("aw_done_%0d", i), 32'(core_done), 32'd0);
      @(negedge clk);
    end
    chk("aw_cs", 32'(bus_cs), 32'd2);
    bus_ack = 4'b0010;
    @(negedge clk);
    bus_ack = '0;
    chk("aw_done",  32'(core_done), 32'd1);
    chk("aw_err",   32'(core_err), 32'd0);
    chk("aw_rdata", core_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    $display("txn %-12s addr=%08h err=%0d rdata=%08h", "ack_wins", 32'h100, core_err, core_rdata);

    // Reset in the second ACCESS cycle of a word store.
    issue(1'b1, 32'h0000_0108, 32'h1122_3344, HB_WORD, 1'b0);
    chk("ra_cs", 32'(bus_cs), 32'd2);
    chk("ra_we", 32'(bus_we), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ra_cs0",    32'(bus_cs), 32'd0);
    chk("ra_we0",    32'(bus_we), 32'd0);
    chk("ra_be0",    32'(bus_be), 32'd0);
    chk("ra_wdata0", bus_wdata, 32'd0);
    chk("ra_baddr0", bus_addr, 32'd0);
    chk("ra_done0",  32'(core_done), 32'd0);
    chk("ra_busy0",  32'(core_busy), 32'd0);
    chk("ra_rdata0", core_rdata, 32'd0);
    @(negedge clk);
    chk("ra_done1",  32'(core_done), 32'd0);
    $display("txn %-12s addr=%08h aborted", "rst_abort", 32'h108);

    run_ack("post_rst",   1'b0, 32'h0000_0204, 32'd0, HB_WORD, 1'b0, 32'h0BAD_F00D,
            4'b0100, 4'b1111, 32'd0, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
